oagu_wr: RTL and testbench

//  Output address generation unit: write-side counterpart to the input AGU. It accepts the PE result stream,

---
 rtl/oagu_wr.sv | 224 ++++++++++++++++++++++
 tb/tb_oagu_wr.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/oagu_wr.sv
// Output address generation unit: buffers PE results in a small FIFO and writes them
// into the IOB using the piece-interleaved line layout (line = X*L words).
module oagu_wr #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [11:0]       i_addr_start,
  input  logic [7:0]        i_out_x_length,
  input  logic [7:0]        i_out_y_length,
  input  logic [7:0]        i_out_layers,
  input  logic              i_res_valid,
  input  logic [DATA_W-1:0] i_res_data,
  output logic              o_res_ready,
  output logic              o_iob_wr_en,
  output logic [11:0]       o_iob_waddr,
  output logic [DATA_W-1:0] o_iob_wdata,
  input  logic              i_iob_wr_gnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CFG  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  xlen_q, xlen_d;
  logic [7:0]  ylen_q, ylen_d;
  logic [7:0]  lay_q, lay_d;
  logic [11:0] line_q, line_d;
  logic [11:0] row_q, row_d;
  logic [11:0] piece_q, piece_d;
  logic [11:0] col_q, col_d;
  logic [7:0]  xc_q, xc_d;
  logic [7:0]  yc_q, yc_d;
  logic [7:0]  lc_q, lc_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic          ready_q, ready_d;
  logic          ovf_q, ovf_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic start_acc;
  logic push;
  logic wr_en;
  logic pop;
  logic last_x;
  logic last_l;
  logic last_y;

  assign start_acc = (state_q == S_IDLE) & i_start;
  assign push      = i_res_valid & ready_q;
  assign wr_en     = (state_q == S_RUN) & (cnt_q != '0);
  assign pop       = wr_en & i_iob_wr_gnt;
  assign last_x    = (xc_q == xlen_q - 8'd1);
  assign last_l    = (lc_q == lay_q - 8'd1);
  assign last_y    = (yc_q == ylen_q - 8'd1);

  // Control and address walk: x innermost, then piece, then row.
  always_comb begin
    state_d = state_q;
    xlen_d  = xlen_q;
    ylen_d  = ylen_q;
    lay_d   = lay_q;
    line_d  = line_q;
    row_d   = row_q;
    piece_d = piece_q;
    col_d   = col_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    lc_d    = lc_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_CFG;
          xlen_d  = i_out_x_length;
          ylen_d  = i_out_y_length;
          lay_d   = i_out_layers;
          row_d   = i_addr_start;
          piece_d = i_addr_start;
          col_d   = i_addr_start;
          xc_d    = 8'd0;
          yc_d    = 8'd0;
          lc_d    = 8'd0;
        end
      end
      S_CFG: begin
        line_d = 12'({8'd0, xlen_q} * {8'd0, lay_q});
        if ((xlen_q == 8'd0) || (ylen_q == 8'd0) || (lay_q == 8'd0)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (pop) begin
          if (!last_x) begin
            xc_d  = xc_q + 8'd1;
            col_d = col_q + {4'd0, lay_q};
          end else begin
            xc_d = 8'd0;
            if (!last_l) begin
              lc_d    = lc_q + 8'd1;
              piece_d = piece_q + 12'd1;
              col_d   = piece_q + 12'd1;
            end else begin
              lc_d = 8'd0;
              if (!last_y) begin
                yc_d    = yc_q + 8'd1;
                row_d   = row_q + line_q;
                piece_d = row_q + line_q;
                col_d   = row_q + line_q;
              end else begin
                state_d = S_DONE;
              end
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (i_res_valid && !ready_q) begin
      ovf_d = 1'b1;
    end
    if (start_acc) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO bookkeeping; a fresh start discards anything left over.
  always_comb begin
    cnt_d = cnt_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      wp_d = wp_q + PTR_ONE;
    end
    if (pop) begin
      rp_d = rp_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    if (start_acc) begin
      cnt_d = '0;
      wp_d  = '0;
      rp_d  = '0;
    end
    ready_d = (state_d == S_RUN) && (cnt_d < CNT_FULL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      xlen_q  <= 8'd0;
      ylen_q  <= 8'd0;
      lay_q   <= 8'd0;
      line_q  <= 12'd0;
      row_q   <= 12'd0;
      piece_q <= 12'd0;
      col_q   <= 12'd0;
      xc_q    <= 8'd0;
      yc_q    <= 8'd0;
      lc_q    <= 8'd0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xlen_q  <= xlen_d;
      ylen_q  <= ylen_d;
      lay_q   <= lay_d;
      line_q  <= line_d;
      row_q   <= row_d;
      piece_q <= piece_d;
      col_q   <= col_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      lc_q    <= lc_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage carries no reset; outputs are gated by wr_en instead.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wp_q] <= i_res_data;
    end
  end

  assign o_res_ready = ready_q;
  assign o_iob_wr_en = wr_en;
  assign o_iob_waddr = wr_en ? col_q : 12'd0;
  assign o_iob_wdata = wr_en ? mem_q[rp_q] : '0;
  assign o_busy      = (state_q == S_CFG) || (state_q == S_RUN);
  assign o_done      = (state_q == S_DONE);
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_oagu_wr.sv
// Scoreboard bench for oagu_wr: a driver pushes expected {addr,data} pairs computed from
// the tiling formula, a negedge monitor pops them on every granted write.
module tb_oagu_wr;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [11:0]       addr_start = 12'd0;
  logic [7:0]        xl = 8'd0;
  logic [7:0]        yl = 8'd0;
  logic [7:0]        ll = 8'd0;
  logic              res_valid = 1'b0;
  logic [DATA_W-1:0] res_data = '0;
  logic              res_ready;
  logic              wr_en;
  logic [11:0]       waddr;
  logic [DATA_W-1:0] wdata;
  logic              gnt = 1'b0;
  logic              busy;
  logic              done;
  logic              ovf;

  int checks = 0;
  int failures = 0;
  int ngrant = 0;
  int done_cnt = 0;
  logic [27:0] exp_q[$];
  logic [27:0] mon_e;
  logic        prev_stall = 1'b0;
  logic [11:0] prev_addr = 12'd0;
  logic [15:0] prev_data = 16'd0;

  oagu_wr #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_addr_start(addr_start),
    .i_out_x_length(xl), .i_out_y_length(yl), .i_out_layers(ll),
    .i_res_valid(res_valid), .i_res_data(res_data), .o_res_ready(res_ready),
    .o_iob_wr_en(wr_en), .o_iob_waddr(waddr), .o_iob_wdata(wdata),
    .i_iob_wr_gnt(gnt), .o_busy(busy), .o_done(done), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each granted write and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_stall) begin
        check("stall_wr_en", 64'(wr_en), 64'd1);
        check("stall_addr", 64'(waddr), 64'(prev_addr));
        check("stall_data", 64'(wdata), 64'(prev_data));
      end
      if (wr_en && gnt) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(waddr), 64'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("waddr", 64'(waddr), 64'(mon_e[27:16]));
          check("wdata", 64'(wdata), 64'(mon_e[15:0]));
        end
        ngrant++;
      end
      prev_stall = wr_en && !gnt;
      prev_addr  = waddr;
      prev_data  = wdata;
    end
  end

  function automatic logic [63:0] outs();
    return 64'({res_ready, wr_en, waddr, wdata, busy, done, ovf});
  endfunction

  // gmode: 0 grant always, 1 random grant, 2 grant low for the first 10 cycles.
  task automatic run_job(input logic [11:0] sa, input int X, input int Y, input int L,
                         input int gmode, input bit vfull, input int flood,
                         input bit glitch, input int abort_at, input bit exp_ovf);
    logic [11:0] addrs[$];
    logic [15:0] d;
    int n;
    int issued;
    int cyc;
    n = X * Y * L;
    addrs.delete();
    for (int y = 0; y < Y; y++)
      for (int l = 0; l < L; l++)
        for (int x = 0; x < X; x++)
          addrs.push_back(12'(int'(sa) + y * X * L + x * L + l));
    exp_q.delete();
    ngrant = 0;
    done_cnt = 0;
    start = 1'b1; addr_start = sa; xl = 8'(X); yl = 8'(Y); ll = 8'(L);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_cfg", 64'(busy), 64'd1);
    check("ovf_cleared_by_start", 64'(ovf), 64'd0);
    issued = 0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      res_valid = 1'b0;
      if (flood > 0 && cyc < flood) begin
        d = 16'($urandom);
        res_valid = 1'b1;
        res_data = d;
        if (res_ready) begin
          exp_q.push_back({addrs[issued], d});
          issued++;
        end
      end else if (res_ready && issued < n && (vfull || $urandom_range(0, 3) != 0)) begin
        d = 16'($urandom);
        res_valid = 1'b1;
        res_data = d;
        exp_q.push_back({addrs[issued], d});
        issued++;
      end
      case (gmode)
        0: gnt = 1'b1;
        1: gnt = 1'($urandom_range(0, 1));
        default: gnt = (cyc >= 10);
      endcase
      if (glitch && cyc == 6) begin
        start = 1'b1; addr_start = 12'h555; xl = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (gmode == 2 && cyc == 10) begin
        check("pushes_before_full", 64'(issued), 64'd4);
        check("ready_low_when_full", 64'(res_ready), 64'd0);
        check("ovf_during_stall", 64'(ovf), 64'(exp_ovf));
      end
      if (abort_at > 0 && ngrant >= abort_at) begin
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 64'd0);
        res_valid = 1'b0; gnt = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_outputs", outs(), 64'd0);
        exp_q.delete();
        gnt = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_reset_idle", outs(), 64'd0);
        return;
      end
    end
    check("done_reached", 64'(done), 64'd1);
    check("busy_low_in_done", 64'(busy), 64'd0);
    res_valid = 1'b0; gnt = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("grant_count", 64'(ngrant), 64'(n));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("idle_after_done", 64'({busy, done}), 64'd0);
    check("ovf_final", 64'(ovf), 64'(exp_ovf));
  endtask

  task automatic zero_job(input int X, input int Y, input int L);
    ngrant = 0;
    done_cnt = 0;
    start = 1'b1; addr_start = 12'h0AB; xl = 8'(X); yl = 8'(Y); ll = 8'(L);
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_cfg_busy", 64'({busy, done, wr_en}), 64'b100);
    @(posedge clk); #1;
    check("zero_done", 64'({busy, done, wr_en}), 64'b010);
    @(posedge clk); #1;
    check("zero_idle", 64'({busy, done, wr_en}), 64'b000);
    check("zero_no_writes", 64'(ngrant), 64'd0);
    check("zero_done_pulses", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outputs", outs(), 64'd0);

    run_job(12'h100, 2, 2, 2, 0, 1'b1, 0, 1'b0, 0, 1'b0);
    run_job(12'h100, 2, 2, 2, 2, 1'b1, 0, 1'b0, 0, 1'b0);
    zero_job(2, 0, 2);
    zero_job(0, 3, 1);
    zero_job(4, 1, 0);
    run_job(12'hFFE, 1, 1, 4, 0, 1'b1, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_job(12'($urandom), $urandom_range(1, 4), $urandom_range(1, 3),
              $urandom_range(1, 4), 1, 1'b0, 0, 1'b0, 0, 1'b0);
    end
    run_job(12'h200, 1, 1, 8, 2, 1'b1, 10, 1'b0, 0, 1'b1);
    run_job(12'h300, 3, 1, 2, 0, 1'b1, 0, 1'b0, 0, 1'b0);
    run_job(12'h100, 2, 2, 2, 0, 1'b1, 0, 1'b0, 3, 1'b0);
    run_job(12'h100, 2, 2, 2, 1, 1'b0, 0, 1'b1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
